// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces per whole scan frame and shifts accepted keys into a 4-digit register.
module keypad_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4
);
    localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE = PW'(1);
    localparam logic [3:0]    DEB     = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] v;
        case ({c, r})
            4'h0:    v = 4'h1;
            4'h1:    v = 4'h4;
            4'h2:    v = 4'h7;
            4'h3:    v = 4'h0;
            4'h4:    v = 4'h2;
            4'h5:    v = 4'h5;
            4'h6:    v = 4'h8;
            4'h7:    v = 4'hF;
            4'h8:    v = 4'h3;
            4'h9:    v = 4'h6;
            4'hA:    v = 4'h9;
            4'hB:    v = 4'hE;
            4'hC:    v = 4'hA;
            4'hD:    v = 4'hB;
            4'hE:    v = 4'hC;
            4'hF:    v = 4'hD;
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_s;
    logic [PW-1:0] r_pre;
    logic [1:0]    r_c;
    logic [3:0]    r_col;
    logic          r_hit;
    logic [3:0]    r_code;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [3:0]    r_cand;
    logic [3:0]    w_cand_nxt;
    logic          w_accept;
    logic [3:0]    r_key;
    logic          r_key_valid;
    logic [3:0]    r_dig1;
    logic [3:0]    r_dig2;
    logic [3:0]    r_dig3;
    logic [3:0]    r_dig4;

    logic          w_tick;
    logic          w_frame_done;
    logic          w_col_hit;
    logic [1:0]    w_row_idx;
    logic          w_acc_hit;
    logic [3:0]    w_acc_code;

    assign w_tick       = (r_pre == PRE_MAX);
    assign w_frame_done = w_tick && (r_c == 2'd3);

    // Two-flop synchronizer for the asynchronous row inputs; idle level is all ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_row_meta <= 4'hF;
            r_row_s    <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_s    <= r_row_meta;
        end
    end

    // Dwell prescaler and column pointer; col is registered so it moves the cycle after tick.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pre <= '0;
            r_c   <= 2'd0;
            r_col <= 4'b1110;
        end else if (w_tick) begin
            r_pre <= '0;
            r_c   <= r_c + 2'd1;
            r_col <= ~(4'b0001 << (r_c + 2'd1));
        end else begin
            r_pre <= r_pre + PRE_ONE;
            r_c   <= r_c;
            r_col <= r_col;
        end
    end

    // Lowest pressed row in the active column, merged with the frame result so far.
    // A hit from an earlier column is kept, which gives lowest-column priority.
    always_comb begin
        w_col_hit  = ~&r_row_s;
        w_row_idx  = 2'd3;
        w_acc_hit  = 1'b0;
        w_acc_code = 4'h0;
        if (!r_row_s[0]) begin
            w_row_idx = 2'd0;
        end else if (!r_row_s[1]) begin
            w_row_idx = 2'd1;
        end else if (!r_row_s[2]) begin
            w_row_idx = 2'd2;
        end else begin
            w_row_idx = 2'd3;
        end
        if ((r_c != 2'd0) && r_hit) begin
            w_acc_hit  = 1'b1;
            w_acc_code = r_code;
        end else if (w_col_hit) begin
            w_acc_hit  = 1'b1;
            w_acc_code = key_map(r_c, w_row_idx);
        end else begin
            w_acc_hit  = 1'b0;
            w_acc_code = 4'h0;
        end
    end

    // Frame accumulator, restarted by the column-0 sample.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_hit  <= 1'b0;
            r_code <= 4'h0;
        end else if (w_tick) begin
            r_hit  <= w_acc_hit;
            r_code <= w_acc_code;
        end else begin
            r_hit  <= r_hit;
            r_code <= r_code;
        end
    end

    // Debounce next-state logic, evaluated only on the frame-completing tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_accept    = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_hit) begin
                        w_cand_nxt = w_acc_code;
                        w_cnt_nxt  = 4'd1;
                        if (DEB == 4'd1) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_state_nxt = ST_CONFIRM;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_CONFIRM: begin
                    if (w_acc_hit && (w_acc_code == r_cand)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                        if ((r_cnt + 4'd1) == DEB) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_HELD;
                        end else begin
                            w_state_nxt = ST_CONFIRM;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (w_acc_hit) begin
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = (DEB == 4'd1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_acc_hit) begin
                        w_cnt_nxt   = r_cnt + 4'd1;
                        w_state_nxt = ((r_cnt + 4'd1) == DEB) ? ST_IDLE : ST_RELEASE;
                    end else begin
                        w_state_nxt = ST_HELD;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    // Accepted key output and entry register; newest digit enters on the right.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_key       <= 4'h0;
            r_key_valid <= 1'b0;
            r_dig1      <= 4'h0;
            r_dig2      <= 4'h0;
            r_dig3      <= 4'h0;
            r_dig4      <= 4'h0;
        end else if (w_accept) begin
            r_key       <= w_cand_nxt;
            r_key_valid <= 1'b1;
            r_dig1      <= r_dig2;
            r_dig2      <= r_dig3;
            r_dig3      <= r_dig4;
            r_dig4      <= w_cand_nxt;
        end else begin
            r_key       <= r_key;
            r_key_valid <= 1'b0;
            r_dig1      <= r_dig1;
            r_dig2      <= r_dig2;
            r_dig3      <= r_dig3;
            r_dig4      <= r_dig4;
        end
    end

    assign col       = r_col;
    assign key       = r_key;
    assign key_valid = r_key_valid;
    assign dig1      = r_dig1;
    assign dig2      = r_dig2;
    assign dig3      = r_dig3;
    assign dig4      = r_dig4;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_scanner: a keypad matrix model drives rows from
// the column drives, and a scoreboard queue holds the expected accepted keys.
module tb_keypad_scanner;
    localparam int  SCAN_DIV = 4;
    localparam int  DEBOUNCE = 2;
    localparam int  FRAME    = 4 * SCAN_DIV;
    localparam time CLK_P    = 10;
    // First press seen in frame 1 after reset -> pulse in cycle DEBOUNCE*FRAME, sampled at negedge.
    localparam time LAT_EXP  = DEBOUNCE * FRAME * CLK_P + CLK_P / 2;

    typedef struct {
        logic [3:0]  k;
        logic [15:0] digs;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic [3:0]  dig1, dig2, dig3, dig4;

    logic [15:0] pressed = 16'h0;
    logic [15:0] m_digs  = 16'h0;
    exp_t        q[$];
    time         t_rst   = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pulses = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .clr(clr), .row(row), .col(col), .key(key), .key_valid(key_valid),
        .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4)
    );

    always #(CLK_P / 2) clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
    end

    // Scoreboard consumer: every key_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        bit   prev_kv = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_kv) begin
                n_checks++;
                if (key_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL pulse_width: key_valid=%b required 0 one cycle after pulse", key_valid);
                end
            end
            if (key_valid === 1'b1) begin
                n_pulses++;
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: key=%h with no pulse required at t=%0t", key, $time);
                end else begin
                    e = q.pop_front();
                    if ({key, dig1, dig2, dig3, dig4} !== {e.k, e.digs}) begin
                        n_errors++;
                        $display("FAIL pulse_data: key/digs=%h/%h%h%h%h required %h/%h",
                                 key, dig1, dig2, dig3, dig4, e.k, e.digs);
                    end
                    if (e.chk_lat) begin
                        n_checks++;
                        if (($time - t_rst) !== LAT_EXP) begin
                            n_errors++;
                            $display("FAIL press_latency: %0t after reset, required %0t", $time - t_rst, LAT_EXP);
                        end
                    end
                end
            end
            prev_kv = key_valid;
        end
    end

    task automatic do_reset();
        clr = 1'b1;
        @(posedge clk);
        t_rst = $time;
        #1;
        clr    = 1'b0;
        m_digs = 16'h0;
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int c, input int r, input bit down);
        pressed[c*4+r] = down;
    endtask

    task automatic expect_key(input logic [3:0] k, input bit lat);
        exp_t e;
        m_digs    = {m_digs[11:0], k};
        e.k       = k;
        e.digs    = m_digs;
        e.chk_lat = lat;
        q.push_back(e);
    endtask

    task automatic test_reset();
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_col;
        pressed = 16'h0;
        do_reset();
        n_checks++;
        if ({col, key, key_valid, dig1, dig2, dig3, dig4} !== {4'b1110, 4'h0, 1'b0, 16'h0}) begin
            n_errors++;
            $display("FAIL reset_values: col/key/kv/digs=%b/%h/%b/%h%h%h%h required 1110/0/0/0000",
                     col, key, key_valid, dig1, dig2, dig3, dig4);
        end
        for (int k = 0; k < FRAME; k++) begin
            exp_col = ~(one << (k / SCAN_DIV));
            n_checks++;
            if (col !== exp_col) begin
                n_errors++;
                $display("FAIL col_scan: cycle %0d col=%b required %b", k, col, exp_col);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_single_key();
        int n0;
        set_key(1, 1, 1'b1);
        do_reset();
        n0 = n_pulses;
        expect_key(4'h5, 1'b1);
        wait_frames(8);
        n_checks++;
        if ((n_pulses - n0) !== 1 || {key, dig1, dig2, dig3, dig4} !== 20'h50005) begin
            n_errors++;
            $display("FAIL single_key: pulses=%0d key=%h digs=%h%h%h%h required 1 5 0005",
                     n_pulses - n0, key, dig1, dig2, dig3, dig4);
        end
        set_key(1, 1, 1'b0);
        wait_frames(3);
    endtask

    task automatic test_entry_shift();
        int          kc[5] = '{0, 1, 2, 3, 0};
        int          kr[5] = '{0, 0, 0, 0, 3};
        logic [3:0]  kv[5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_key(kc[i], kr[i], 1'b1);
            expect_key(kv[i], 1'b0);
            wait_frames(3);
            set_key(kc[i], kr[i], 1'b0);
            wait_frames(3);
            if (i == 3) begin
                n_checks++;
                if ({dig1, dig2, dig3, dig4} !== 16'h123A) begin
                    n_errors++;
                    $display("FAIL entry_shift4: digs=%h%h%h%h required 123A", dig1, dig2, dig3, dig4);
                end
            end
        end
        n_checks++;
        if ({dig1, dig2, dig3, dig4} !== 16'h23A0) begin
            n_errors++;
            $display("FAIL entry_shift5: digs=%h%h%h%h required 23A0", dig1, dig2, dig3, dig4);
        end
    endtask

    task automatic test_bounce();
        int n0 = n_pulses;
        set_key(2, 0, 1'b1);
        wait_frames(1);
        set_key(2, 0, 1'b0);
        wait_frames(3);
        n_checks++;
        if ((n_pulses - n0) !== 0 || {key, dig1, dig2, dig3, dig4} !== 20'h023A0) begin
            n_errors++;
            $display("FAIL bounce: pulses=%0d key=%h digs=%h%h%h%h required 0 0 23A0",
                     n_pulses - n0, key, dig1, dig2, dig3, dig4);
        end
    endtask

    task automatic test_priority();
        int n0 = n_pulses;
        set_key(0, 0, 1'b1);
        set_key(3, 0, 1'b1);
        expect_key(4'h1, 1'b0);
        wait_frames(3);
        n_checks++;
        if (key !== 4'h1) begin
            n_errors++;
            $display("FAIL priority_key: key=%h required 1", key);
        end
        set_key(0, 0, 1'b0);
        wait_frames(4);
        set_key(3, 0, 1'b0);
        wait_frames(3);
        n_checks++;
        if ((n_pulses - n0) !== 1) begin
            n_errors++;
            $display("FAIL priority_repress: pulses=%0d required 1", n_pulses - n0);
        end
    endtask

    task automatic test_release_glitch();
        int n0 = n_pulses;
        set_key(1, 2, 1'b1);
        expect_key(4'h8, 1'b0);
        wait_frames(3);
        set_key(1, 2, 1'b0);
        wait_frames(1);
        set_key(1, 2, 1'b1);
        wait_frames(3);
        n_checks++;
        if ((n_pulses - n0) !== 1) begin
            n_errors++;
            $display("FAIL release_glitch: pulses=%0d required 1", n_pulses - n0);
        end
        set_key(1, 2, 1'b0);
        wait_frames(3);
        set_key(1, 2, 1'b1);
        expect_key(4'h8, 1'b0);
        wait_frames(3);
        set_key(1, 2, 1'b0);
        wait_frames(3);
        n_checks++;
        if ((n_pulses - n0) !== 2 || key !== 4'h8) begin
            n_errors++;
            $display("FAIL release_repress: pulses=%0d key=%h required 2 8", n_pulses - n0, key);
        end
    endtask

    task automatic test_reset_mid_confirm();
        set_key(2, 2, 1'b1);
        wait_frames(1);
        do_reset();
        n_checks++;
        if ({col, key, key_valid, dig1, dig2, dig3, dig4} !== {4'b1110, 4'h0, 1'b0, 16'h0}) begin
            n_errors++;
            $display("FAIL mid_reset_values: col/key/kv/digs=%b/%h/%b/%h%h%h%h required 1110/0/0/0000",
                     col, key, key_valid, dig1, dig2, dig3, dig4);
        end
        expect_key(4'h9, 1'b1);
        wait_frames(4);
        set_key(2, 2, 1'b0);
        wait_frames(3);
        n_checks++;
        if ({dig1, dig2, dig3, dig4} !== 16'h0009) begin
            n_errors++;
            $display("FAIL mid_reset_digs: digs=%h%h%h%h required 0009", dig1, dig2, dig3, dig4);
        end
    endtask

    task automatic test_queue_drained(input string name);
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_pulse_%s: %0d pulses outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_queue_drained("single");
        test_entry_shift();
        test_queue_drained("entry");
        test_bounce();
        test_priority();
        test_queue_drained("priority");
        test_release_glitch();
        test_queue_drained("glitch");
        test_reset_mid_confirm();
        test_queue_drained("midreset");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
